// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_ARMED  = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_shift_reg.sv
// Load/shift-right data register for the UART transmitter, serial output from bit 0.
// With UART_TX_PARITY_EN defined it also latches the frame parity at load time.
module uart_tx_shift_reg #(
  parameter int unsigned DATA_WIDTH = 8
`ifdef UART_TX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef UART_TX_PARITY_EN
  output logic                  parity,
`endif
  output logic                  serial
);

  logic [DATA_WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= data_in;
    end else if (shift) begin
      sr_q <= {1'b0, sr_q[DATA_WIDTH-1:1]};
    end
  end

  assign serial = sr_q[0];

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Captured from the accepted byte; the shift register is consumed before the parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= (^data_in) ^ (PARITY_ODD != 0);
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: byte handshake in, framed serial line out, timed by an external baud strobe.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  tx_done_o
);

  localparam int unsigned     CntW     = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_fsm: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fsm: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_fsm: PARITY_ODD must be 0 or 1");
  end

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic            load, shift, done;
  logic            serial_bit;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
`endif

  uart_tx_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PARITY_ODD)
`endif
  ) u_shift_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .data_in(tx_data_i),
`ifdef UART_TX_PARITY_EN
    .parity (parity_bit),
`endif
    .serial (serial_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is decoded from the current state, so the line trails each state change by one clk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = UART_IDLE_LVL;
    load    = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;

    case (state_q)
      TX_IDLE: begin
        // A tick in the accept cycle is deliberately not consumed: ARMED lasts a full period.
        if (tx_valid_i) begin
          load    = 1'b1;
          state_d = TX_ARMED;
        end
      end
      TX_ARMED: begin
        if (baud_tick) begin
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = UART_START_LVL;
        if (baud_tick) begin
          state_d = TX_DATA;
          cnt_d   = '0;
        end
      end
      TX_DATA: begin
        tx_d = serial_bit;
        if (baud_tick) begin
          shift = 1'b1;
          if (cnt_q < DataLast) begin
            cnt_d = cnt_q + CntW'(1);
          end else begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        tx_d = parity_bit;
        if (baud_tick) begin
          state_d = TX_STOP;
          cnt_d   = '0;
        end
      end
`endif
      TX_STOP: begin
        if (baud_tick) begin
          if (cnt_q < StopLast) begin
            cnt_d = cnt_q + CntW'(1);
          end else begin
            cnt_d   = '0;
            state_d = TX_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (state_q == TX_IDLE);
  assign busy_o     = (state_q != TX_IDLE);
  // Reset wins over a coincident final stop tick, so an aborted frame never reports done.
  assign tx_done_o  = done & ~rst;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: two instances (1 stop/even, 2 stop/odd) against a frame model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_fsm;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  int            sel;
  int            tick_period;
  int            tick_cnt;

  logic valid_a, ready_a, tx_a, busy_a, done_a;
  logic valid_b, ready_b, tx_b, busy_b, done_b;
  logic ready_obs, tx_obs, busy_obs, done_obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  assign valid_a   = tx_valid && (sel == 0);
  assign valid_b   = tx_valid && (sel == 1);
  assign ready_obs = (sel == 0) ? ready_a : ready_b;
  assign tx_obs    = (sel == 0) ? tx_a : tx_b;
  assign busy_obs  = (sel == 0) ? busy_a : busy_b;
  assign done_obs  = (sel == 0) ? done_a : done_b;

  uart_tx_fsm #(.DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tx_data_i (tx_data),
    .tx_valid_i(valid_a),
    .tx_ready_o(ready_a),
    .tx_o      (tx_a),
    .busy_o    (busy_a),
    .tx_done_o (done_a)
  );

  uart_tx_fsm #(.DATA_WIDTH(DW), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tx_data_i (tx_data),
    .tx_valid_i(valid_b),
    .tx_ready_o(ready_b),
    .tx_o      (tx_b),
    .busy_o    (busy_b),
    .tx_done_o (done_b)
  );

  // Baud strobe: one clk high every tick_period clks, or tied high when tick_period is 1.
  initial begin
    baud_tick = 1'b0;
    tick_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period <= 1) begin
        baud_tick = 1'b1;
      end else begin
        tick_cnt  = (tick_cnt + 1) % tick_period;
        baud_tick = (tick_cnt == 0);
      end
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame for the selected instance: start, data LSB-first, parity, stop bits.
  task automatic build_frame(input logic [DW-1:0] d);
    int  stops;
    bit  odd;
    int  ones;
    stops = (sel == 0) ? 1 : 2;
    odd   = (sel == 1);
    ones  = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_EN) exp_q.push_back(((ones % 2) == 1) != odd);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic accept(input logic [DW-1:0] d, input bit hold);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready_obs) break;
    end
    check("accept_ready", ready_obs, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data  = DW'($urandom);
    end
  endtask

  task automatic check_frame(input logic [DW-1:0] d, input int min_idle);
    int  p;
    int  n;
    int  idle;
    bit  found;
    p     = (tick_period < 1) ? 1 : tick_period;
    idle  = 0;
    found = 1'b0;
    build_frame(d);
    for (int i = 0; i < 4 * p + 8; i++) begin
      @(negedge clk);
      if (tx_obs === 1'b0) begin
        found = 1'b1;
        break;
      end
      idle++;
    end
    check("start_bit_seen", found, 1'b1);
    if (!found) return;
    if (min_idle > 0) check("idle_gap", idle >= min_idle, 1'b1);
    n = exp_q.size() * p;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("line_bit%0d_d%02h", k / p, d), tx_obs, exp_q[k / p]);
      check($sformatf("done_k%0d", k), done_obs, k == n - 2);
      if (k == 0) begin
        check("busy_in_frame", busy_obs, 1'b1);
        check("ready_in_frame", ready_obs, 1'b0);
      end
      if (k == n - 1) begin
        check("ready_after_done", ready_obs, 1'b1);
        check("busy_after_done", busy_obs, 1'b0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    bit bad;
    rst         = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;
    sel         = 0;
    tick_period = 16;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_ready_a", ready_a, 1'b1);
    check("rst_done_a", done_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_ready_b", ready_b, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of the data bits aborts the frame
    accept(8'h5A, 1'b0);
    for (int i = 0; i < 100 && tx_a !== 1'b0; i++) @(negedge clk);
    repeat (4 * 16) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", tx_a, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_ready", ready_a, 1'b1);
    check("abort_done", done_a, 1'b0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || done_a !== 1'b0) bad = 1'b1;
    end
    check("abort_quiet", bad, 1'b0);

    // Basic frame, 16 clks per bit
    accept(8'hA5, 1'b0);
    check_frame(8'hA5, 0);

    // Parity polarity on both instances
    tick_period = 4;
    sel = 0;
    accept(8'h07, 1'b0);
    check_frame(8'h07, 0);
    sel = 1;
    accept(8'h07, 1'b0);
    check_frame(8'h07, 0);

    // Two stop bits
    accept(8'hFF, 1'b0);
    check_frame(8'hFF, 0);

    // Valid held with changing data during a frame
    tick_period = 16;
    sel = 0;
    accept(8'h96, 1'b1);
    tx_data = 8'h3B;
    check_frame(8'h96, 0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hC4;
    check_frame(8'h3B, 16);

    // Tick tied high: one bit per clk
    tick_period = 1;
    sel = 0;
    accept(8'h3C, 1'b0);
    check_frame(8'h3C, 0);
    sel = 1;
    accept(8'h3C, 1'b0);
    check_frame(8'h3C, 0);

    // Randomised frames
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       tick_period = 1;
        1:       tick_period = 2;
        2:       tick_period = 3;
        default: tick_period = 7;
      endcase
      d = DW'($urandom);
      accept(d, 1'b0);
      check_frame(d, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
